// File: rtl/fft_pkg.sv
// Shared types and helpers for the in-place radix-2 DIF FFT sequencer.
// FFT_SEQ_BITREV_EN adds the natural-order unscramble pass state.
package fft_pkg;

  localparam int unsigned MAX_LOG2N = 12;

`ifdef FFT_SEQ_BITREV_EN
  typedef enum logic [2:0] {StIdle, StRun, StDrain, StUnscramble, StFinish} state_e;
`else
  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFinish} state_e;
`endif

  function automatic bit log2n_ok(input int v);
    return (v >= 2) && (v <= int'(MAX_LOG2N));
  endfunction

  function automatic bit rd_lat_ok(input int v);
    return v >= 1;
  endfunction

  function automatic bit bf_lat_ok(input int v);
    return v >= 0;
  endfunction

  // Reverses the low `width` bits of v; bits above width come back as 0.
  function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] v,
                                                  input int unsigned width);
    logic [MAX_LOG2N-1:0] r;
    logic [MAX_LOG2N-1:0] t;
    r = '0;
    t = v;
    for (int unsigned i = 0; i < MAX_LOG2N; i++) begin
      if (i < width) begin
        r = {r[MAX_LOG2N-2:0], t[0]};
        t = t >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_seq_if.sv
// Control/status and memory-strobe bundle between fft_seq and its memory/datapath.
interface fft_seq_if #(
  parameter int LOG2N = 10
) ();
  localparam int SW = $clog2(LOG2N + 1);

  logic             start;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr_a;
  logic [LOG2N-1:0] rd_addr_b;
  logic [LOG2N-2:0] tw_idx;
  logic             tw_valid;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr_a;
  logic [LOG2N-1:0] wr_addr_b;
  logic [SW-1:0]    stage;

  modport master (
    input  start,
    output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx, tw_valid,
           wr_en, wr_addr_a, wr_addr_b, stage
  );

  modport slave (
    output start,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx, tw_valid,
           wr_en, wr_addr_a, wr_addr_b, stage
  );
endinterface

// File: rtl/fft_addr_gen.sv
// Combinational DIF butterfly address/twiddle generator: inserts a 0/1 at bit
// b = LOG2N-1-s of the butterfly counter and forms k = (j mod 2^b) << s.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N = 10
) (
  input  logic [LOG2N-2:0]             i_j,
  input  logic [$clog2(LOG2N+1)-1:0]   i_s,
  output logic [LOG2N-1:0]             o_addr_a,
  output logic [LOG2N-1:0]             o_addr_b,
  output logic [LOG2N-2:0]             o_tw_idx
);
  localparam int SW = $clog2(LOG2N + 1);

  logic [SW-1:0]    w_b;
  logic [LOG2N-1:0] w_bit;
  logic [LOG2N-1:0] w_mask;
  logic [LOG2N-1:0] w_j_ext;

  assign w_b     = SW'(LOG2N - 1) - i_s;
  assign w_bit   = LOG2N'(1) << w_b;
  assign w_mask  = w_bit - LOG2N'(1);
  assign w_j_ext = {1'b0, i_j};

  // Bits at and above b move up one place to open the gap for the pair bit.
  assign o_addr_a = ((w_j_ext & ~w_mask) << 1) | (w_j_ext & w_mask);
  assign o_addr_b = o_addr_a | w_bit;
  assign o_tw_idx = (i_j & w_mask[LOG2N-2:0]) << i_s;

endmodule

// File: rtl/fft_seq.sv
// In-place radix-2 DIF FFT sequencer: walks LOG2N stages of N/2 butterflies,
// drains the pipeline between stages. FFT_SEQ_BITREV_EN adds an unscramble pass.
module fft_seq
  import fft_pkg::*;
#(
  parameter int LOG2N  = 10,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  fft_seq_if.master  bus
);
  localparam int LAT = RD_LAT + BF_LAT;
  localparam int SW  = $clog2(LOG2N + 1);
  localparam int DCW = $clog2(LAT + 1);
  localparam logic [LOG2N-2:0] J_LAST = '1;

  if (!(log2n_ok(LOG2N) && rd_lat_ok(RD_LAT) && bf_lat_ok(BF_LAT))) begin : g_bad_param
    $error("fft_seq: illegal LOG2N/RD_LAT/BF_LAT");
  end

  state_e           r_state, w_state_d;
  logic [LOG2N-2:0] r_j, w_j_d;
  logic [SW-1:0]    r_s, w_s_d;
  logic [DCW-1:0]   r_dcnt, w_dcnt_d;
  logic             w_run, w_busy, w_done, w_unscr_rd;
  logic             w_rd_en;
  logic [LOG2N-1:0] w_rd_a, w_rd_b, w_gen_a, w_gen_b;
  logic [LOG2N-2:0] w_gen_tw;
`ifdef FFT_SEQ_BITREV_EN
  localparam logic [LOG2N-1:0] K_LAST = '1;
  logic [LOG2N-1:0]     r_k, w_k_d;
  logic                 r_tail, w_tail_d;
  logic [MAX_LOG2N-1:0] w_rev;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_j     <= '0;
      r_s     <= '0;
      r_dcnt  <= '0;
`ifdef FFT_SEQ_BITREV_EN
      r_k     <= '0;
      r_tail  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_d;
      r_j     <= w_j_d;
      r_s     <= w_s_d;
      r_dcnt  <= w_dcnt_d;
`ifdef FFT_SEQ_BITREV_EN
      r_k     <= w_k_d;
      r_tail  <= w_tail_d;
`endif
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_j_d      = r_j;
    w_s_d      = r_s;
    w_dcnt_d   = r_dcnt;
    w_run      = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    w_unscr_rd = 1'b0;
`ifdef FFT_SEQ_BITREV_EN
    w_k_d      = r_k;
    w_tail_d   = r_tail;
`endif
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_state_d = StRun;
          w_j_d     = '0;
          w_s_d     = '0;
        end
      end
      StRun: begin
        w_run  = 1'b1;
        w_busy = 1'b1;
        w_j_d  = r_j + (LOG2N-1)'(1);
        if (r_j == J_LAST) begin
          w_state_d = StDrain;
          w_dcnt_d  = '0;
        end
      end
      StDrain: begin
        w_busy   = 1'b1;
        w_dcnt_d = r_dcnt + DCW'(1);
        if (r_dcnt == DCW'(LAT - 1)) begin
          if (r_s == SW'(LOG2N - 1)) begin
`ifdef FFT_SEQ_BITREV_EN
            w_state_d = StUnscramble;
            w_k_d     = '0;
            w_tail_d  = 1'b0;
`else
            w_state_d = StFinish;
`endif
          end else begin
            w_state_d = StRun;
            w_s_d     = r_s + SW'(1);
            w_j_d     = '0;
          end
        end
      end
`ifdef FFT_SEQ_BITREV_EN
      StUnscramble: begin
        w_busy = 1'b1;
        if (!r_tail) begin
          w_unscr_rd = 1'b1;
          w_k_d      = r_k + LOG2N'(1);
          if (r_k == K_LAST) begin
            if (RD_LAT == 1) begin
              w_state_d = StFinish;
            end else begin
              w_tail_d = 1'b1;
              w_dcnt_d = '0;
            end
          end
        end else begin
          // Wait out the read latency so the last word is valid with done.
          w_dcnt_d = r_dcnt + DCW'(1);
          if (r_dcnt == DCW'(RD_LAT - 2)) begin
            w_state_d = StFinish;
          end
        end
      end
`endif
      StFinish: begin
        w_done    = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  fft_addr_gen #(
    .LOG2N (LOG2N)
  ) u_addr_gen (
    .i_j      (r_j),
    .i_s      (r_s),
    .o_addr_a (w_gen_a),
    .o_addr_b (w_gen_b),
    .o_tw_idx (w_gen_tw)
  );

`ifdef FFT_SEQ_BITREV_EN
  assign w_rev   = bitrev(MAX_LOG2N'(r_k), LOG2N);
  assign w_rd_en = w_run | w_unscr_rd;
  assign w_rd_a  = w_run ? w_gen_a : (w_unscr_rd ? w_rev[LOG2N-1:0] : '0);
`else
  assign w_rd_en = w_run;
  assign w_rd_a  = w_run ? w_gen_a : '0;
`endif
  assign w_rd_b  = w_run ? w_gen_b : '0;

  // Write-back delay line: only butterfly reads produce writes.
  for (genvar gi = 0; gi < LAT; gi++) begin : g_wr_dly
    logic             w_v_in;
    logic [LOG2N-1:0] w_a_in, w_b_in;
    logic             r_v;
    logic [LOG2N-1:0] r_a, r_b;
    if (gi == 0) begin : g_head
      assign w_v_in = w_run;
      assign w_a_in = w_run ? w_gen_a : '0;
      assign w_b_in = w_run ? w_gen_b : '0;
    end else begin : g_tail
      assign w_v_in = g_wr_dly[gi-1].r_v;
      assign w_a_in = g_wr_dly[gi-1].r_a;
      assign w_b_in = g_wr_dly[gi-1].r_b;
    end
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_a <= '0;
        r_b <= '0;
      end else begin
        r_v <= w_v_in;
        r_a <= w_a_in;
        r_b <= w_b_in;
      end
    end
  end

  for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_tw_dly
    logic             w_v_in;
    logic [LOG2N-2:0] w_t_in;
    logic             r_v;
    logic [LOG2N-2:0] r_t;
    if (gi == 0) begin : g_head
      assign w_v_in = w_run;
      assign w_t_in = w_run ? w_gen_tw : '0;
    end else begin : g_tail
      assign w_v_in = g_tw_dly[gi-1].r_v;
      assign w_t_in = g_tw_dly[gi-1].r_t;
    end
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_t <= '0;
      end else begin
        r_v <= w_v_in;
        r_t <= w_t_in;
      end
    end
  end

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.rd_en     = w_rd_en;
  assign bus.rd_addr_a = w_rd_a;
  assign bus.rd_addr_b = w_rd_b;
  assign bus.tw_valid  = g_tw_dly[RD_LAT-1].r_v;
  assign bus.tw_idx    = g_tw_dly[RD_LAT-1].r_t;
  assign bus.wr_en     = g_wr_dly[LAT-1].r_v;
  assign bus.wr_addr_a = g_wr_dly[LAT-1].r_a;
  assign bus.wr_addr_b = g_wr_dly[LAT-1].r_b;
  assign bus.stage     = w_busy ? r_s : '0;

endmodule

// File: tb/tb_fft_seq.sv
// Scoreboard bench for fft_seq (N=8, RD_LAT=1, BF_LAT=2): a reference model
// pushes timed read/twiddle/write/done events; a negedge monitor pops and compares.
module tb_fft_seq;
  localparam int L   = 3;
  localparam int RDL = 1;
  localparam int BFL = 2;
  localparam int LAT = RDL + BFL;
  localparam int N   = 1 << L;
  localparam int P   = N / 2 + LAT;
`ifdef FFT_SEQ_BITREV_EN
  localparam int TOTAL = L * P + N + RDL - 1;
`else
  localparam int TOTAL = L * P;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_seq_if #(.LOG2N(L)) bus ();

  fft_seq #(
    .LOG2N  (L),
    .RD_LAT (RDL),
    .BF_LAT (BFL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int cyc;
    int a;
    int b;
  } ev_t;

  ev_t rd_q[$];
  ev_t tw_q[$];
  ev_t wr_q[$];
  int  done_q[$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  int busy_lo = 0;
  int busy_hi = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic int bitrev_m(input int v, input int w);
    int r = 0;
    int t = v;
    repeat (w) begin
      r = r * 2 + t % 2;
      t = t / 2;
    end
    return r;
  endfunction

  // Reference: standard DIF butterfly spans; events after `limit` are cut off by reset.
  task automatic push_xform(input int c0, input int limit);
    for (int s = 0; s < L; s++) begin
      int half = N >> (s + 1);
      for (int j = 0; j < N / 2; j++) begin
        int t = c0 + s * P + j;
        int a = (j / half) * 2 * half + (j % half);
        int tw = (j % half) * (1 << s);
        if (t <= limit)       rd_q.push_back('{t, a, a + half});
        if (t + RDL <= limit) tw_q.push_back('{t + RDL, tw, 0});
        if (t + LAT <= limit) wr_q.push_back('{t + LAT, a, a + half});
      end
    end
`ifdef FFT_SEQ_BITREV_EN
    for (int k = 0; k < N; k++) begin
      int t = c0 + L * P + k;
      if (t <= limit) rd_q.push_back('{t, bitrev_m(k, L), 0});
    end
`endif
    if (c0 + TOTAL <= limit) done_q.push_back(c0 + TOTAL);
  endtask

  always @(negedge clk) begin
    ev_t e;
    bit  in_busy;
    int  exp_stage;
    if (mon_en) begin
      if (bus.rd_en) begin
        if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          e = rd_q.pop_front();
          check("rd_cycle", cyc, e.cyc);
          check("rd_addr_a", int'(bus.rd_addr_a), e.a);
          check("rd_addr_b", int'(bus.rd_addr_b), e.b);
        end
      end else begin
        check("rd_addr_idle", int'(bus.rd_addr_a) + int'(bus.rd_addr_b), 0);
      end
      if (bus.tw_valid) begin
        if (tw_q.size() == 0) check("tw_unexpected", 1, 0);
        else begin
          e = tw_q.pop_front();
          check("tw_cycle", cyc, e.cyc);
          check("tw_idx", int'(bus.tw_idx), e.a);
        end
      end else begin
        check("tw_idx_idle", int'(bus.tw_idx), 0);
      end
      if (bus.wr_en) begin
        if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          e = wr_q.pop_front();
          check("wr_cycle", cyc, e.cyc);
          check("wr_addr_a", int'(bus.wr_addr_a), e.a);
          check("wr_addr_b", int'(bus.wr_addr_b), e.b);
        end
      end else begin
        check("wr_addr_idle", int'(bus.wr_addr_a) + int'(bus.wr_addr_b), 0);
      end
      if (bus.done) begin
        if (done_q.size() == 0) check("done_unexpected", 1, 0);
        else check("done_cycle", cyc, done_q.pop_front());
      end
      in_busy = (cyc >= busy_lo) && (cyc < busy_hi);
      check("busy", int'(bus.busy), int'(in_busy));
      if (in_busy) begin
        exp_stage = (cyc - busy_lo) / P;
        if (exp_stage > L - 1) exp_stage = L - 1;
        check("stage", int'(bus.stage), exp_stage);
      end else begin
        check("stage_idle", int'(bus.stage), 0);
      end
    end
  end

  // mode 0: start noise while busy; 1: start held through done then dropped;
  // 2: start held into the following IDLE (chains a new transform); 3: reset in stage 1.
  task automatic run_xform(input int mode, input bit chained);
    int c0, d, r, limit;
    if (!chained) begin
      repeat ($urandom_range(4, 2)) @(negedge clk);
      bus.start = 1'b1;
    end
    c0 = cyc + 1;
    d  = c0 + TOTAL;
    r  = 0;
    if (mode == 3) begin
      r       = c0 + P + int'($urandom_range(P - 1, 0));
      limit   = r;
      busy_hi = r + 1;
    end else begin
      limit   = 1 << 30;
      busy_hi = d;
    end
    busy_lo = c0;
    push_xform(c0, limit);
    @(negedge clk);
    if (mode == 3) begin
      while (cyc < r) begin
        bus.start = 1'($urandom_range(1, 0));
        @(negedge clk);
      end
      rst_n     = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      check("rst_mid_busy", int'(bus.busy), 0);
      check("rst_mid_rd_en", int'(bus.rd_en), 0);
      check("rst_mid_wr_en", int'(bus.wr_en), 0);
      rst_n = 1'b1;
    end else begin
      if (mode != 0) bus.start = 1'b1;
      while (cyc < d) begin
        if (mode == 0) bus.start = 1'($urandom_range(1, 0));
        @(negedge clk);
      end
      if (mode == 2) @(negedge clk);
      else bus.start = 1'b0;
    end
  endtask

  initial begin
    int mode, prev;
    bus.start = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_rd_en", int'(bus.rd_en), 0);
    check("reset_wr_en", int'(bus.wr_en), 0);
    check("reset_tw_valid", int'(bus.tw_valid), 0);
    check("reset_rd_addr_a", int'(bus.rd_addr_a), 0);
    check("reset_rd_addr_b", int'(bus.rd_addr_b), 0);
    check("reset_wr_addr_a", int'(bus.wr_addr_a), 0);
    check("reset_wr_addr_b", int'(bus.wr_addr_b), 0);
    check("reset_tw_idx", int'(bus.tw_idx), 0);
    check("reset_stage", int'(bus.stage), 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    run_xform(0, 1'b0);
    run_xform(1, 1'b0);
    run_xform(2, 1'b0);
    run_xform(0, 1'b1);
    run_xform(3, 1'b0);
    run_xform(0, 1'b0);
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      mode = int'($urandom_range(3, 0));
      run_xform(mode, prev == 2);
      prev = mode;
    end
    if (prev == 2) run_xform(0, 1'b1);

    repeat (20) @(negedge clk);
    check("rd_left", rd_q.size(), 0);
    check("tw_left", tw_q.size(), 0);
    check("wr_left", wr_q.size(), 0);
    check("done_left", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
